// File: rtl/reg8_serial_tx.sv
// reg8_serial_tx
// Parallel-in, serial-out transmitter for one 8-bit register byte.
// A byte captured on load is shifted out one bit per clock with a framing
// strobe (sframe), followed by a one-cycle completion pulse (done).
// A stall input freezes the frame in place without losing data.
//
// Optional feature: define REG8_TX_PARITY_EN to append an even-parity bit
// after the eighth data bit, making the frame 9 bits long.
module reg8_serial_tx #(
   parameter bit   MSB_FIRST  = 1'b1,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       load,
   input  logic [7:0] D,
   input  logic       stall,
   output logic       ready,
   output logic       sframe,
   output logic       sdata,
   output logic       done
);

`ifdef REG8_TX_PARITY_EN
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      DONE   = 2'd2,
      PARITY = 2'd3
   } txState_t;
`else
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      DONE   = 2'd2
   } txState_t;
`endif

   txState_t   r_state;
   txState_t   w_nextState;
   logic [7:0] r_shift;
   logic [2:0] r_count;
   logic       w_currentBit;
   logic       w_capture;
   logic       w_advance;

`ifdef REG8_TX_PARITY_EN
   logic       r_parity;
`endif

   // The bit on the wire is taken from whichever end of the shift register
   // leads, so the shift direction below must match this choice.
   assign w_currentBit = MSB_FIRST ? r_shift[7] : r_shift[0];

   // A capture only happens from IDLE; load anywhere else is ignored.
   assign w_capture = (r_state == IDLE) && load;

   // One data bit is consumed per unstalled SHIFT cycle.
   assign w_advance = (r_state == SHIFT) && !stall;

   // State register; reset aborts any frame in progress without a done pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Shift register and bit counter: load on capture, move one place per
   // unstalled SHIFT cycle, otherwise hold so a stall never loses data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_shift <= 8'h00;
         r_count <= 3'd0;
      end else if (w_capture) begin
         r_shift <= D;
         r_count <= 3'd0;
      end else if (w_advance) begin
         if (MSB_FIRST) begin
            r_shift <= {r_shift[6:0], 1'b0};
         end else begin
            r_shift <= {1'b0, r_shift[7:1]};
         end
         r_count <= r_count + 3'd1;
      end
   end

`ifdef REG8_TX_PARITY_EN
   // Even parity of the captured byte, computed once at capture so it stays
   // valid after the data bits have been shifted away.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_parity <= 1'b0;
      end else if (w_capture) begin
         r_parity <= ^D;
      end
   end
`endif

   // Next-state decode and Moore outputs; every output is a pure function of
   // the registered state so the reset values appear asynchronously.
   always_comb begin
      w_nextState = r_state;
      ready       = 1'b0;
      sframe      = 1'b0;
      sdata       = IDLE_LEVEL;
      done        = 1'b0;

      case (r_state)
         IDLE: begin
            ready = 1'b1;
            if (load) begin
               w_nextState = SHIFT;
            end
         end

         SHIFT: begin
            sframe = 1'b1;
            sdata  = w_currentBit;
            if (!stall && (r_count == 3'd7)) begin
`ifdef REG8_TX_PARITY_EN
               w_nextState = PARITY;
`else
               w_nextState = DONE;
`endif
            end
         end

`ifdef REG8_TX_PARITY_EN
         PARITY: begin
            sframe = 1'b1;
            sdata  = r_parity;
            if (!stall) begin
               w_nextState = DONE;
            end
         end
`endif

         DONE: begin
            done        = 1'b1;
            w_nextState = IDLE;
         end

         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_reg8_serial_tx.sv
// Testbench for reg8_serial_tx: an MSB-first instance checked against a
// scoreboard of expected frame bits, plus an LSB-first instance with directed
// checks.
module tb_reg8_serial_tx;

`ifdef REG8_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic       clk;
   logic       reset_n;
   logic       load;
   logic [7:0] D;
   logic       stall;
   logic       ready;
   logic       sframe;
   logic       sdata;
   logic       done;

   logic       loadLsb;
   logic [7:0] dLsb;
   logic       stallLsb;
   logic       readyLsb;
   logic       sframeLsb;
   logic       sdataLsb;
   logic       doneLsb;

   int         vectorCount = 0;
   int         missCount   = 0;
   int         sframeCount = 0;
   logic       expQ[$];
   logic       lastBit = 1'b0;
   logic       tbHeld;

   reg8_serial_tx #(.MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_dut (
      .clk(clk), .reset_n(reset_n), .load(load), .D(D), .stall(stall),
      .ready(ready), .sframe(sframe), .sdata(sdata), .done(done)
   );

   reg8_serial_tx #(.MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_dutLsb (
      .clk(clk), .reset_n(reset_n), .load(loadLsb), .D(dLsb), .stall(stallLsb),
      .ready(readyLsb), .sframe(sframeLsb), .sdata(sdataLsb), .done(doneLsb)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so a stuck design still ends the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at time %0t, expected finish", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h at time %0t",
                  tag, observed, expected, $time);
      end
   endtask

   // Remembers whether the frame was told to hold at the last edge, so the
   // monitor knows the bit on the wire is a repeat rather than a new one.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tbHeld <= 1'b0;
      end else begin
         tbHeld <= sframe & stall;
      end
   end

   // Monitor: every framed cycle either repeats the held bit or consumes the
   // next expected bit from the scoreboard.
   always @(negedge clk) begin
      if (reset_n && sframe) begin
         sframeCount++;
         if (tbHeld) begin
            checkOutput("heldBit", {31'd0, sdata}, {31'd0, lastBit});
         end else if (expQ.size() == 0) begin
            checkOutput("queueUnderflow", 32'd1, 32'd0);
         end else begin
            lastBit = expQ.pop_front();
            checkOutput("frameBit", {31'd0, sdata}, {31'd0, lastBit});
         end
      end
   end

   // Queue the expected wire bits for one MSB-first frame.
   task automatic pushFrame(input logic [7:0] d);
      for (int b = 0; b < 8; b++) begin
         expQ.push_back(d[7 - b]);
      end
      if (PAR == 1) begin
         expQ.push_back(^d);
      end
   endtask

   // Drive one frame on the MSB-first instance and check its timing.
   // stallStart is the cycle offset from the capture edge where stall begins.
   task automatic applyStimulus(input logic [7:0] d, input int stallStart,
                                input int stallLen, input bit glitchLoad);
      int  expDone;
      bit  seenDone;
      bit  seenReady;
      expDone   = 9 + PAR + stallLen;
      seenDone  = 1'b0;
      seenReady = 1'b0;

      for (int w = 0; w < 20 && !seenReady; w++) begin
         @(negedge clk);
         if (ready) seenReady = 1'b1;
      end
      checkOutput("readyBeforeLoad", {31'd0, seenReady}, 32'd1);

      D    = d;
      load = 1'b1;
      pushFrame(d);
      sframeCount = 0;
      @(posedge clk);
      #1;
      load = 1'b0;
      D    = ~d;

      for (int k = 1; k <= 30 && !seenDone; k++) begin
         @(negedge clk);
         stall = (k >= stallStart) && (k < stallStart + stallLen);
         if (glitchLoad) begin
            load = (k == 4);
            D    = 8'hFF;
         end
         if (done) begin
            seenDone = 1'b1;
            stall    = 1'b0;
            checkOutput("doneCycle", k, expDone);
            checkOutput("queueEmptyAtDone", expQ.size(), 32'd0);
            checkOutput("sframeCycles", sframeCount, 8 + PAR + stallLen);
            checkOutput("readyLowAtDone", {31'd0, ready}, 32'd0);
         end
      end
      stall = 1'b0;
      load  = 1'b0;
      if (!seenDone) begin
         checkOutput("doneTimeout", 32'd0, 32'd1);
      end

      @(negedge clk);
      checkOutput("readyAfterDone", {31'd0, ready}, 32'd1);
      checkOutput("donePulseWidth", {31'd0, done}, 32'd0);
      checkOutput("idleSdata", {31'd0, sdata}, 32'd0);
   endtask

   initial begin
      reset_n  = 1'b1;
      load     = 1'b0;
      D        = 8'h00;
      stall    = 1'b0;
      loadLsb  = 1'b0;
      dLsb     = 8'h00;
      stallLsb = 1'b0;

      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("resetReady", {31'd0, ready}, 32'd1);
      checkOutput("resetSframe", {31'd0, sframe}, 32'd0);
      checkOutput("resetDone", {31'd0, done}, 32'd0);
      checkOutput("resetSdata", {31'd0, sdata}, 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      $display("[TB] frame A5, no stall");
      applyStimulus(8'hA5, 0, 0, 1'b0);

      $display("[TB] frame C3, bit 2 held by three stall cycles");
      applyStimulus(8'hC3, 3, 3, 1'b0);

      $display("[TB] frame 00 with a stray load of FF mid-frame");
      applyStimulus(8'h00, 0, 0, 1'b1);

      $display("[TB] frame 5A aborted by reset at bit 4");
      @(negedge clk);
      D    = 8'h5A;
      load = 1'b1;
      pushFrame(8'h5A);
      @(posedge clk);
      #1;
      load = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      expQ.delete();
      checkOutput("abortReady", {31'd0, ready}, 32'd1);
      checkOutput("abortSframe", {31'd0, sframe}, 32'd0);
      checkOutput("abortDone", {31'd0, done}, 32'd0);
      checkOutput("abortSdata", {31'd0, sdata}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         checkOutput("noDoneAfterAbort", {31'd0, done}, 32'd0);
      end

      $display("[TB] frame 3C after reset");
      applyStimulus(8'h3C, 0, 0, 1'b0);

      $display("[TB] parity-sensitive frames 07 and 03");
      applyStimulus(8'h07, 0, 0, 1'b0);
      applyStimulus(8'h03, 0, 0, 1'b0);

      $display("[TB] LSB-first frame 01");
      @(negedge clk);
      dLsb    = 8'h01;
      loadLsb = 1'b1;
      @(posedge clk);
      #1;
      loadLsb = 1'b0;
      dLsb    = 8'hFE;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         checkOutput("lsbBit", {31'd0, sdataLsb}, (k == 1) ? 32'd1 : 32'd0);
         checkOutput("lsbSframe", {31'd0, sframeLsb}, 32'd1);
      end
      if (PAR == 1) begin
         @(negedge clk);
         checkOutput("lsbParity", {31'd0, sdataLsb}, 32'd1);
         checkOutput("lsbParitySframe", {31'd0, sframeLsb}, 32'd1);
      end
      @(negedge clk);
      checkOutput("lsbSframeEnd", {31'd0, sframeLsb}, 32'd0);
      checkOutput("lsbDone", {31'd0, doneLsb}, 32'd1);
      @(negedge clk);
      checkOutput("lsbReady", {31'd0, readyLsb}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
